activity_impulse_gen: RTL and testbench

ACTIVITY_IMPULSE_GEN -- requirements
Module: activity_impulse_gen

---
 rtl/activity_pkg.sv | 22 ++
 rtl/activity_channel.sv | 127 ++++++++++++
 rtl/activity_impulse_gen.sv | 47 ++++
 tb/tb_activity_impulse_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/activity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : activity_pkg
// Description : Shared types and default parameter values for the activity
//               impulse generator (per-channel FSM state encoding).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package activity_pkg;

    localparam int unsigned DEFAULT_NUM_CHANNELS   = 4;
    localparam int unsigned DEFAULT_FILTER_CYCLES  = 4;
    localparam int unsigned DEFAULT_HOLDOFF_CYCLES = 1 << 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } act_state_e;

endpackage
`default_nettype wire

// File: rtl/activity_channel.sv
`default_nettype none
// ============================================================================
// Module      : activity_channel
// Description : One activity channel: input register, level filter, impulse
//               FSM (IDLE/FIRE/HOLDOFF) and holdoff counter.
// Ports       : clk_i     - clock (rising edge)
//               rst_i     - synchronous active-high reset
//               event_i   - raw activity level, synchronous to clk_i
//               force_i   - one-cycle software trigger, bypasses the filter
//               enable_i  - low suppresses new impulses and drops pending
//               impulse_o - registered one-cycle impulse
//               busy_o    - high while the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module activity_channel
    import activity_pkg::*;
#(
    parameter int unsigned FilterCycles  = DEFAULT_FILTER_CYCLES,
    parameter int unsigned HoldoffCycles = DEFAULT_HOLDOFF_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic event_i,
    input  logic force_i,
    input  logic enable_i,
    output logic impulse_o,
    output logic busy_o
);

    localparam int unsigned c_filt_w = (FilterCycles  > 1) ? $clog2(FilterCycles)  : 1;
    localparam int unsigned c_hold_w = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FilterCycles - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HoldoffCycles - 1);

    logic                raw_q;
    logic                filt_q,  filt_d;
    logic [c_filt_w-1:0] fcnt_q,  fcnt_d;
    logic [c_hold_w-1:0] hcnt_q;
    logic                pending_q;
    logic                impulse_q;
    logic                busy_q;
    act_state_e          state_q;
    logic                w_event;

    // Level filter: a difference must persist for FilterCycles consecutive
    // cycles before it is accepted; the acceptance edge is an activity event.
    always_comb begin
        filt_d  = filt_q;
        fcnt_d  = '0;
        w_event = force_i;
        if (raw_q != filt_q) begin
            if (fcnt_q == c_filt_last) begin
                filt_d  = raw_q;
                w_event = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_q  <= 1'b0;
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            raw_q  <= event_i;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Impulse FSM. impulse_q mirrors "state is FIRE" and busy_q mirrors
    // "state is not IDLE", both registered alongside the state itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            pending_q <= 1'b0;
            impulse_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            impulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pending_q <= 1'b0;
                    if (w_event && enable_i) begin
                        state_q   <= ST_FIRE;
                        impulse_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_q   <= ST_HOLDOFF;
                    hcnt_q    <= c_hold_last;
                    pending_q <= w_event && enable_i;
                end
                ST_HOLDOFF: begin
                    if (hcnt_q == '0) begin
                        // An event arriving on this very edge still counts.
                        pending_q <= 1'b0;
                        if ((pending_q || w_event) && enable_i) begin
                            state_q   <= ST_FIRE;
                            impulse_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        hcnt_q    <= hcnt_q - 1'b1;
                        pending_q <= (pending_q || w_event) && enable_i;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign impulse_o = impulse_q;
    assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: rtl/activity_impulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : activity_impulse_gen
// Description : Turns filtered activity on NumChannels independent lines (or
//               software strobes) into rate-limited one-cycle impulses.
// Ports       : clk_i     - clock (rising edge)
//               rst_i     - synchronous active-high reset
//               event_i   - raw activity levels, one bit per channel
//               force_i   - one-cycle software triggers per channel
//               enable_i  - per-channel enable
//               impulse_o - registered one-cycle impulses per channel
//               busy_o    - per-channel FSM not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module activity_impulse_gen
    import activity_pkg::*;
#(
    parameter int unsigned NumChannels   = DEFAULT_NUM_CHANNELS,
    parameter int unsigned FilterCycles  = DEFAULT_FILTER_CYCLES,
    parameter int unsigned HoldoffCycles = DEFAULT_HOLDOFF_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumChannels-1:0] event_i,
    input  logic [NumChannels-1:0] force_i,
    input  logic [NumChannels-1:0] enable_i,
    output logic [NumChannels-1:0] impulse_o,
    output logic [NumChannels-1:0] busy_o
);

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        activity_channel #(
            .FilterCycles  (FilterCycles),
            .HoldoffCycles (HoldoffCycles)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .event_i   (event_i[g]),
            .force_i   (force_i[g]),
            .enable_i  (enable_i[g]),
            .impulse_o (impulse_o[g]),
            .busy_o    (busy_o[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_activity_impulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_activity_impulse_gen
// Description : Self-checking bench for activity_impulse_gen (N=4, F=4,
//               H=16). Expected impulse cycles are queued per channel when
//               stimulus is driven and compared as impulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_activity_impulse_gen;

    localparam int N = 4;
    localparam int F = 4;
    localparam int H = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ev;
    logic [N-1:0] frc;
    logic [N-1:0] en;
    logic [N-1:0] imp;
    logic [N-1:0] busy;

    int cyc     = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[N][$];
    int mon_e;

    activity_impulse_gen #(
        .NumChannels   (N),
        .FilterCycles  (F),
        .HoldoffCycles (H)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .event_i   (ev),
        .force_i   (frc),
        .enable_i  (en),
        .impulse_o (imp),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_imp(input int ch, input int c);
        exp_q[ch].push_back(c);
    endtask

    // Scoreboard: every impulse seen must match the head of its channel queue.
    always @(negedge clk) begin
        for (int ch = 0; ch < N; ch++) begin
            if (imp[ch] === 1'b1) begin
                if (exp_q[ch].size() == 0) begin
                    check($sformatf("imp_unexpected_ch%0d", ch), int'(imp[ch]), 0);
                end else begin
                    mon_e = exp_q[ch].pop_front();
                    check($sformatf("imp_cycle_ch%0d", ch), cyc, mon_e);
                end
            end
        end
    end

    initial begin
        int n;
        int bcnt;

        // Reset, with ch3 event held high and force strobes ignored.
        rst = 1'b1; ev = 4'b1000; frc = '0; en = '1;
        step(2);
        frc = '1;
        step(1);
        frc = '0;
        step(1);
        check("rst_impulse", int'(imp), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        n = cyc;
        expect_imp(3, n + 1 + F);
        step(1);
        check("post_rst_impulse", int'(imp), 0);
        step(30);

        // ch0 level rise: impulse after F edges, busy for H+1 cycles.
        n = cyc;
        ev[0] = 1'b1;
        expect_imp(0, n + 1 + F);
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (busy[0]) bcnt++;
        end
        check("busy_len_ch0", bcnt, H + 1);
        step(5);

        // ch1: 3-cycle glitch filtered out; 4-cycle pulse gives rise + fall.
        ev[1] = 1'b1; step(3); ev[1] = 1'b0;
        step(12);
        n = cyc;
        ev[1] = 1'b1; step(4); ev[1] = 1'b0;
        expect_imp(1, n + 1 + F);
        expect_imp(1, n + 1 + F + H + 1);
        step(40);

        // ch0: ten force strobes, nine of them during one HOLDOFF.
        n = cyc;
        frc[0] = 1'b1;
        expect_imp(0, n + 1);
        expect_imp(0, n + 1 + H + 1);
        step(1); frc[0] = 1'b0; step(1);
        for (int i = 0; i < 9; i++) begin
            frc[0] = 1'b1; step(1);
        end
        frc[0] = 1'b0;
        step(40);

        // ch2 disabled: toggling level gives nothing, nor does re-enable.
        en[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev[2] = ~ev[2]; step(7);
        end
        ev[2] = 1'b0; step(10);
        check("dis_busy_ch2", int'(busy[2]), 0);
        en[2] = 1'b1;
        step(30);
        check("reen_busy_ch2", int'(busy[2]), 0);

        // ch2: pending dropped by a one-cycle enable low during HOLDOFF.
        n = cyc;
        frc[2] = 1'b1;
        expect_imp(2, n + 1);
        step(1); frc[2] = 1'b0; step(2);
        frc[2] = 1'b1; step(1); frc[2] = 1'b0;
        en[2] = 1'b0; step(1); en[2] = 1'b1;
        check("hold_busy_ch2", int'(busy[2]), 1);
        step(n + H + 2 - cyc);
        check("hold_done_ch2", int'(busy[2]), 0);
        step(30);

        // ch1: reset mid-HOLDOFF with pending set aborts everything.
        n = cyc;
        frc[1] = 1'b1;
        expect_imp(1, n + 1);
        step(1); frc[1] = 1'b0; step(2);
        frc[1] = 1'b1; step(1); frc[1] = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        check("mid_rst_busy", int'(busy), 0);
        step(1);
        rst = 1'b0;
        n = cyc;
        // Levels still high on ch0/ch3 look like fresh changes after reset.
        expect_imp(0, n + 1 + F);
        expect_imp(3, n + 1 + F);
        step(1);
        check("mid_rst_release_imp", int'(imp), 0);
        step(30);

        // ch1: force landing exactly on the holdoff counter==0 edge.
        n = cyc;
        frc[1] = 1'b1;
        expect_imp(1, n + 1);
        expect_imp(1, n + 1 + H + 1);
        step(1); frc[1] = 1'b0;
        step(n + H + 1 - cyc);
        frc[1] = 1'b1; step(1); frc[1] = 1'b0;
        step(40);

        // All channels forced together fire together.
        n = cyc;
        frc = '1;
        for (int ch = 0; ch < N; ch++) expect_imp(ch, n + 1);
        step(1); frc = '0;
        step(25);

        for (int ch = 0; ch < N; ch++)
            check($sformatf("missing_imp_ch%0d", ch), exp_q[ch].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
